// File: rtl/port_queue_scheduler.sv
// port_queue_scheduler: pending-packet bookkeeping and queue selection for
// the 8 priority queues of one egress port. One grant is outstanding at a
// time. The next arbitration waits until the read sequencer reports the
// end of the granted packet.
module port_queue_scheduler #(
  parameter int num_of_priorities = 8,
  parameter int priority_width    = 3,
  parameter int wrr_weight_width  = 4,
  parameter int pkt_cnt_width     = 6
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          sp0_wrr1,
  input  logic                                          enq_vld,
  input  logic [priority_width-1:0]                     enq_priority,
  input  logic [num_of_priorities-1:0]                  ready,
  input  logic [num_of_priorities*wrr_weight_width-1:0] wrr_weight,
  output logic                                          grant_vld,
  output logic [priority_width-1:0]                     grant_priority,
  input  logic                                          grant_ack,
  input  logic                                          pkt_done,
  output logic [num_of_priorities-1:0]                  prepared,
  output logic [num_of_priorities*pkt_cnt_width-1:0]    pending_cnt,
  output logic                                          enq_err,
  output logic                                          busy
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t state, state_next;

  logic [pkt_cnt_width-1:0]    cnt        [num_of_priorities];
  logic [wrr_weight_width-1:0] credit     [num_of_priorities];
  logic [wrr_weight_width-1:0] eff_weight [num_of_priorities];

  logic [num_of_priorities-1:0] eligible;
  logic [num_of_priorities-1:0] enq_hit;
  logic [num_of_priorities-1:0] deq_hit;
  logic [priority_width-1:0]    rr_ptr;
  logic [priority_width-1:0]    sp_sel;
  logic [priority_width-1:0]    wrr_sel;
  logic [priority_width-1:0]    scan_idx;
  logic [priority_width-1:0]    grant_priority_next;
  logic                         any_eligible;
  logic                         wrr_found;
  logic                         grant_vld_next;
  logic                         reload;
  logic                         accept;
  logic                         wrr_mode_q;
  logic                         wrr_mode_next;

  assign accept = grant_vld & grant_ack;
  assign busy   = (state == GRANT) || (state == XFER);

  // Per-queue views: effective weights, eligibility, counter taps and packed outputs
  always_comb begin
    pending_cnt = '0;
    for (int p = 0; p < num_of_priorities; p++) begin
      eff_weight[p] = wrr_weight[p*wrr_weight_width +: wrr_weight_width];
      if (eff_weight[p] == '0) eff_weight[p] = wrr_weight_width'(1);
      prepared[p] = (cnt[p] != '0);
      eligible[p] = prepared[p] & ready[p];
      enq_hit[p]  = enq_vld && (enq_priority == priority_width'(p));
      deq_hit[p]  = accept && (grant_priority == priority_width'(p));
      pending_cnt[p*pkt_cnt_width +: pkt_cnt_width] = cnt[p];
    end
    any_eligible = |eligible;
  end

  // Candidate selection: lowest eligible index for SP, credit-holding scan from rr_ptr for WRR
  always_comb begin
    sp_sel    = '0;
    wrr_sel   = '0;
    wrr_found = 1'b0;
    scan_idx  = '0;
    for (int p = num_of_priorities - 1; p >= 0; p--) begin
      if (eligible[p]) sp_sel = priority_width'(p);
    end
    for (int i = 0; i < num_of_priorities; i++) begin
      scan_idx = rr_ptr + priority_width'(i);
      if (!wrr_found && eligible[scan_idx] && (credit[scan_idx] != '0)) begin
        wrr_found = 1'b1;
        wrr_sel   = scan_idx;
      end
    end
  end

  // FSM next state and registered grant outputs; a WRR miss with eligible work triggers a credit reload
  always_comb begin
    state_next          = state;
    grant_vld_next      = grant_vld;
    grant_priority_next = grant_priority;
    wrr_mode_next       = wrr_mode_q;
    reload              = 1'b0;
    case (state)
      IDLE: begin
        if (any_eligible) begin
          if (!sp0_wrr1) begin
            grant_vld_next      = 1'b1;
            grant_priority_next = sp_sel;
            wrr_mode_next       = 1'b0;
            state_next          = GRANT;
          end else if (wrr_found) begin
            grant_vld_next      = 1'b1;
            grant_priority_next = wrr_sel;
            wrr_mode_next       = 1'b1;
            state_next          = GRANT;
          end else begin
            reload = 1'b1;
          end
        end
      end
      GRANT: begin
        if (accept) begin
          grant_vld_next = 1'b0;
          state_next     = XFER;
        end
      end
      XFER: begin
        if (pkt_done) state_next = IDLE;
      end
      default: begin
        state_next     = IDLE;
        grant_vld_next = 1'b0;
      end
    endcase
  end

  // State register and grant output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant_vld      <= 1'b0;
      grant_priority <= '0;
      wrr_mode_q     <= 1'b0;
    end else begin
      state          <= state_next;
      grant_vld      <= grant_vld_next;
      grant_priority <= grant_priority_next;
      wrr_mode_q     <= wrr_mode_next;
    end
  end

  // WRR credits and round-robin pointer: reload on a starved scan, spend one credit per accepted WRR grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int p = 0; p < num_of_priorities; p++) credit[p] <= eff_weight[p];
    end else if (reload) begin
      for (int p = 0; p < num_of_priorities; p++) credit[p] <= eff_weight[p];
    end else if (accept && wrr_mode_q) begin
      credit[grant_priority] <= credit[grant_priority] - wrr_weight_width'(1);
      if (credit[grant_priority] == wrr_weight_width'(1)) rr_ptr <= grant_priority + priority_width'(1);
      else                                                rr_ptr <= grant_priority;
    end
  end

  // Pending counters: enqueue adds, accept removes, both on one queue cancel, overflow is dropped and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      enq_err <= 1'b0;
      for (int p = 0; p < num_of_priorities; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < num_of_priorities; p++) begin
        if (enq_hit[p] && !deq_hit[p]) begin
          if (cnt[p] == '1) enq_err <= 1'b1;
          else              cnt[p]  <= cnt[p] + pkt_cnt_width'(1);
        end else if (deq_hit[p] && !enq_hit[p]) begin
          cnt[p] <= cnt[p] - pkt_cnt_width'(1);
        end
      end
    end
  end

endmodule

// File: doc/port_queue_scheduler.md
Name: port_queue_scheduler

Overview:
- Per-output-port scheduler: tracks pending packet counts for the 8 priority queues of one egress port.
- Selects which priority queue the SRAM read sequencer drains next, using strict priority (SP) or weighted round robin (WRR).
- Sits between the cache manager's enqueue notifications and the per-port SRAM read path; one instance per output port (16 in top).
- Issues one packet grant at a time and waits for packet completion before arbitrating again.

Parameters:
- num_of_priorities, 8, number of priority queues per port
- priority_width, 3, width of a priority index
- wrr_weight_width, 4, width of one WRR weight
- pkt_cnt_width, 6, width of each pending-packet counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sp0_wrr1  input  1  scheduling mode: 0 = strict priority, 1 = WRR; sampled only in IDLE
- enq_vld  input  1  one packet of priority enq_priority has been fully written to cache for this port
- enq_priority  input  priority_width  priority of the enqueued packet
- ready  input  num_of_priorities  downstream per-priority ready; bit p gates eligibility of queue p
- wrr_weight  input  num_of_priorities*wrr_weight_width  packed weights; queue p at bits [p*W +: W]
- grant_vld  output  1  grant offered to the read sequencer
- grant_priority  output  priority_width  queue being granted
- grant_ack  input  1  read sequencer accepts the grant
- pkt_done  input  1  read sequencer emitted eop of the granted packet
- prepared  output  num_of_priorities  bit p = pending_cnt[p] != 0
- pending_cnt  output  num_of_priorities*pkt_cnt_width  packed per-queue counters
- enq_err  output  1  sticky: an enqueue hit a saturated counter
- busy  output  1  high in GRANT or XFER

Behaviour:
- Reset values: grant_vld 0, grant_priority 0, all pending_cnt 0, prepared 0, enq_err 0, busy 0. FSM = IDLE, rr_ptr = 0, credit[p] = eff_weight[p].
- eff_weight[p] = wrr_weight[p], except weight 0 is treated as 1.
- eligible[p] = (pending_cnt[p] != 0) & ready[p].
- Counters:
  - enq_vld increments pending_cnt[enq_priority].
  - Accept (grant_vld & grant_ack) decrements pending_cnt[grant_priority].
  - Both on the same queue in the same cycle: count unchanged.
  - Enqueue at all-ones with no same-cycle decrement: enqueue dropped, enq_err set; enq_err clears only on rst.
- prepared is combinational from the registered counters.
- FSM IDLE:
  - If any eligible queue exists, a selection is made; grant_vld and grant_priority are registered, so grant_vld rises the cycle after eligibility is seen. Go to GRANT.
  - SP mode: lowest index eligible wins (priority 0 highest).
  - WRR mode: scan from rr_ptr upward (mod 8) for the first queue that is eligible and has credit[p] > 0.
  - WRR with eligible queues but none holding credit: reload all credit[p] = eff_weight[p] that cycle, make no grant, and stay in IDLE. Selection happens the next cycle.
- FSM GRANT:
  - grant_vld and grant_priority are held stable until grant_ack; the grant is never retracted, even if ready drops.
  - On accept: grant_vld goes to 0 next cycle, and the FSM moves to XFER.
  - WRR mode on accept: credit[p] decrements. If the new credit is 0, rr_ptr becomes p+1 mod 8; otherwise rr_ptr becomes p.
- FSM XFER:
  - Wait for pkt_done, then return to IDLE.
  - pkt_done in any other state is ignored.
  - Minimum spacing between grants: accept at cycle t, pkt_done at t+1, next grant_vld at t+3.
- sp0_wrr1 changes take effect at the next IDLE evaluation. Credits are not reset on a mode change.
- rst asserted mid-operation: all state returns to reset values the next cycle and any in-flight grant is abandoned.

Test Plan:
- SP ordering: enqueue one packet each on priorities 5, 2, 7 with ready all 1, SP mode, ack each grant immediately and pulse pkt_done one cycle later. Required grant order: 2, 5, 7; pending_cnt returns to 0; prepared goes 0.
- WRR weights: weights q0=2, q1=1, 4 packets on each of q0 and q1, WRR mode. Required grant order: 0,0,1,0,0,1,1,1; a reload cycle with no grant occurs when both credits are exhausted.
- Ready gating: q0 pending with ready[0]=0 and q3 pending with ready[3]=1, SP mode. Required: grant q3. Dropping ready[3] while in GRANT leaves grant_vld=1 and grant_priority=3 until ack.
- Saturation: 63 enqueues on q4, then a 64th. Required: pending_cnt[4] = 63 and enq_err = 1. A simultaneous enqueue plus accept on q4 leaves the count at 63.
- Reset mid-XFER: assert rst for 1 cycle during XFER. Required: next cycle busy=0, grant_vld=0, all counters 0, enq_err=0.
- Zero weight: weight q2=0, 3 packets on q2, WRR mode. Required: q2 is granted once per reload (treated as weight 1); all 3 packets are served.
